// File: rtl/s2p_frame_ctrl.sv
// Serial framing receiver: start/data/stop framing on bit_en strobes,
// one-entry valid/ready output buffer, sticky frame/overrun error flags.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   enable           low forces IDLE; buffer and flags are kept
//   bit_en           bit sample strobe; serial_in is only used when high
//   serial_in        serial line, idle high, data sent LSB first
//   out_ready        consumer accepts out_data this cycle
//   err_clr          clears frame_err and overrun
//   out_data         received word, valid while out_valid is high
//   out_valid        holding register full
//   busy             high while in DATA or STOP
//   frame_err        sticky, stop bit sampled low
//   overrun          sticky, good frame arrived while buffer held a word
module s2p_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             bit_en,
  input  logic             serial_in,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic             load;
  logic             ovr_set;
  logic             fe_set;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    load      = 1'b0;
    ovr_set   = 1'b0;
    fe_set    = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else if (bit_en) begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (!serial_in) begin
            state_nxt = S_DATA;
            cnt_nxt   = '0;
          end
        end
        (state == S_DATA): begin
          sr_nxt  = {serial_in, sr[WIDTH-1:1]};
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST) begin
            state_nxt = S_STOP;
          end
        end
        (state == S_STOP): begin
          state_nxt = S_IDLE;
          if (!serial_in) begin
            fe_set = 1'b1;
          end else if (!out_valid || out_ready) begin
            load = 1'b1;
          end else begin
            ovr_set = 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      sr    <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  // A load in the same cycle as a drain keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= sr;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Set wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_set  | (frame_err & ~err_clr);
      overrun   <= ovr_set | (overrun & ~err_clr);
    end
  end

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Bench for s2p_frame_ctrl: directed frames, word scoreboard popped
// by a monitor on each out_valid/out_ready handshake.
module tb_s2p_frame_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         bit_en;
  logic         serial_in;
  logic         out_ready;
  logic         err_clr;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  s2p_frame_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .bit_en    (bit_en),
    .serial_in (serial_in),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word: got %0h expected none", out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL word: got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit1(input logic b);
    bit_en    = 1'b1;
    serial_in = b;
    tick();
    bit_en    = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic data_bits(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) bit1(w[i]);
  endtask

  task automatic frame(input logic [W-1:0] w, input logic stop);
    bit1(1'b0);
    data_bits(w);
    bit1(stop);
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    bit_en    = 1'b0;
    serial_in = 1'b1;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_busy",  32'(busy),      0);
    chk("rst_flags", 32'({frame_err, overrun}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Good frame 0xD
    bit1(1'b0);
    chk("busy_data", 32'(busy), 1);
    data_bits(4'hD);
    chk("busy_stop", 32'(busy), 1);
    chk("valid_early", 32'(out_valid), 0);
    exp_q.push_back(4'hD);
    bit1(1'b1);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data",  32'(out_data),  32'hD);
    chk("t1_ferr",  32'(frame_err), 0);
    chk("t1_busy",  32'(busy),      0);
    pulse_ready();
    chk("t1_drain", 32'(out_valid), 0);
    chk("t1_hold",  32'(out_data),  32'hD);

    // Framing error
    frame(4'b0110, 1'b0);
    chk("t2_ferr",  32'(frame_err), 1);
    chk("t2_valid", 32'(out_valid), 0);
    bit1(1'b1);
    chk("t2_idle",  32'(busy), 0);
    pulse_clr();
    chk("t2_clr",   32'(frame_err), 0);

    // Overrun
    exp_q.push_back(4'hA);
    frame(4'hA, 1'b1);
    frame(4'h5, 1'b1);
    chk("t3_data",  32'(out_data),  32'hA);
    chk("t3_valid", 32'(out_valid), 1);
    chk("t3_ovr",   32'(overrun),   1);
    chk("t3_ferr",  32'(frame_err), 0);
    pulse_ready();
    chk("t3_drain", 32'(out_valid), 0);
    pulse_clr();
    chk("t3_clr",   32'(overrun), 0);

    // Back-to-back with out_ready held
    out_ready = 1'b1;
    exp_q.push_back(4'h3);
    exp_q.push_back(4'hC);
    frame(4'h3, 1'b1);
    frame(4'hC, 1'b1);
    chk("t4_valid", 32'(out_valid), 1);
    chk("t4_data",  32'(out_data),  32'hC);
    tick();
    tick();
    out_ready = 1'b0;
    chk("t4_flags", 32'({frame_err, overrun}), 0);
    chk("t4_empty", 32'(exp_q.size()), 0);

    // Reset mid-frame
    bit1(1'b0);
    bit1(1'b1);
    bit1(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy),     0);
    chk("t5_data", 32'(out_data), 0);
    chk("t5_all",  32'({out_valid, frame_err, overrun}), 0);
    #3 rst_n = 1'b1;
    tick();
    exp_q.push_back(4'h9);
    frame(4'h9, 1'b1);
    chk("t5_valid", 32'(out_valid), 1);
    chk("t5_word",  32'(out_data),  32'h9);
    pulse_ready();

    // enable low mid-frame
    bit1(1'b0);
    bit1(1'b1);
    chk("t6_busy1", 32'(busy), 1);
    enable = 1'b0;
    bit_en = 1'b1;
    serial_in = 1'b0;
    tick();
    chk("t6_busy0", 32'(busy), 0);
    tick();
    tick();
    enable = 1'b1;
    bit_en = 1'b0;
    serial_in = 1'b1;
    tick();
    chk("t6_nvalid", 32'(out_valid), 0);
    chk("t6_nflag",  32'({frame_err, overrun}), 0);
    exp_q.push_back(4'h6);
    frame(4'h6, 1'b1);
    chk("t6_data", 32'(out_data), 32'h6);
    bit1(1'b0);
    data_bits(4'h7);
    err_clr = 1'b1;
    bit1(1'b1);
    err_clr = 1'b0;
    chk("t6_ovr_win", 32'(overrun),  1);
    chk("t6_keep",    32'(out_data), 32'h6);
    pulse_clr();
    chk("t6_ovr_clr", 32'(overrun), 0);
    pulse_ready();
    chk("t6_drain", 32'(out_valid), 0);

    tick();
    chk("end_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s2p_frame_ctrl.md
# s2p_frame_ctrl

Framing controller and output buffer for the serial-to-parallel receive path. Detects a start bit on a serial line sampled by an external bit strobe and shifts WIDTH data bits LSB-first. It checks the stop bit and presents the assembled word through a one-entry valid/ready holding register. Framing and overrun errors are reported as sticky flags; the block sits between the pad-level serial input and the parallel consumer logic in the top-level wrapper.

## Interface
- WIDTH, 4, number of data bits per frame (2..8)
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  block enable; low forces IDLE synchronously, buffer and flags kept
- bit_en  input  1  one-cycle strobe marking a bit sample point; serial_in only evaluated when high
- serial_in  input  1  serial line, idle high
- out_ready  input  1  consumer accepts out_data this cycle
- err_clr  input  1  clears frame_err and overrun
- out_data  output  WIDTH  received word, valid when out_valid=1
- out_valid  output  1  holding register full
- busy  output  1  high in DATA or STOP state
- frame_err  output  1  sticky: stop bit sampled low
- overrun  output  1  sticky: good frame arrived while buffer full and not drained

## Operation
- Reset (rst_n=0, async): state=IDLE, shift register=0, bit counter=0, out_data=0, out_valid=0, busy=0, frame_err=0, overrun=0.
- States: IDLE, DATA, STOP; busy = (state!=IDLE), registered with state.
- IDLE: bit_en & serial_in=0 → DATA, counter=0. bit_en & serial_in=1 → stay.
- DATA: on bit_en, shift right: sr <= {serial_in, sr[WIDTH-1:1]}; counter++. On the bit_en with counter==WIDTH-1 → STOP. First data bit ends in sr[0].
- STOP, on bit_en:
  - serial_in=1 and (out_valid=0 or out_ready=1): out_data<=sr, out_valid<=1.
  - serial_in=1, out_valid=1, out_ready=0: word dropped, out_data unchanged, overrun<=1.
  - serial_in=0: word dropped, frame_err<=1; this low is NOT a start bit.
  - All cases → IDLE.
- Drain: out_valid & out_ready with no same-cycle load → out_valid<=0 (out_data holds last value). Load and drain in the same cycle → out_valid stays 1 with the new word.
- err_clr clears both sticky flags; a set event in the same cycle wins (flag stays 1).
- enable=0: next state IDLE, counter=0, sr held, bit_en ignored; drain via out_ready still works. Partial frame is discarded silently (no flag).
- bit_en=0 cycles: no state, shift or counter change.

## Timing
- out_valid rises the cycle after the STOP-state bit_en; word latency = start bit_en + WIDTH data strobes + stop strobe, +1 clk.
- frame_err/overrun rise the cycle after the offending stop strobe.
- out_data stable whenever out_valid=1 and out_ready=0.
- bit_en may be asserted on consecutive cycles (one bit per clock, max rate); the FSM must sustain back-to-back frames with a start bit on the strobe immediately after the stop strobe.
- rst_n deassertion mid-frame: block starts in IDLE; the next low sample on bit_en is taken as a start bit.
- No combinational path from inputs to outputs.

## Test plan
- WIDTH=4, one-clock strobes, serial 0,1,0,1,1,1 (start, d0..d3=1,0,1,1, stop) → out_valid=1 one cycle after stop strobe, out_data=4'hD, frame_err=0; out_ready pulse → out_valid=0 next cycle.
- Frame 0,0,1,1,0,0 (stop low) → frame_err=1, out_valid unchanged; the next strobe at serial_in=1 stays IDLE; err_clr → frame_err=0.
- Two good frames 4'hA then 4'h5 with out_ready=0 → out_data=4'hA kept, overrun=1; then out_ready=1 for one cycle → out_valid=0.
- Back-to-back frames 4'h3 then 4'hC, out_ready=1 held, start strobe right after stop strobe → two out_valid cycles carrying 4'h3 then 4'hC, no flags.
- rst_n pulse low after 2 data bits of a frame → all outputs 0 immediately; following full frame 4'h9 received correctly.
- enable=0 for 3 cycles mid-frame → busy=0 next cycle, no out_valid; with out_valid=1, err_clr and overrun set in the same cycle → overrun stays 1.
